sim_sequencer: RTL and testbench
================================

Name: sim_sequencer

Overview:
- Run controller between the switch/button inputs and physics_engine.
- Debounces the 16-bit scenario select and latches it for initial_selector.
- Holds the engine in load for a fixed window after any accepted selection change, then issues rate-divided step pulses.
- Supports pause, single-step while paused, and a saturating collision-event counter for display/debug.

Parameters:
- DEBOUNCE, 1_620_000, consecutive stable cycles required on sel_raw before acceptance (10 ms at 162 MHz); >=1
- LOAD_CYCLES, 16, cycles load is held high per (re)initialization; >=1
- STEP_DIV, 2_700_000, clock cycles per step pulse in RUN (~60 Hz at 162 MHz); >=1

Ports:
- clock_162  input  1  system clock (161.905 MHz from clocking wizard)
- rst  input  1  synchronous, active-high reset
- sel_raw  input  16  raw scenario switches
- pause_btn  input  1  pause/resume toggle, already debounced, level
- step_btn  input  1  single-step request, already debounced, level
- collision  input  1  collision flag from physics_engine, level
- sel_latched  output  16  accepted scenario index to initial_selector
- load  output  1  engine initialize: reload init locations/velocities
- step_en  output  1  one-cycle engine advance pulse
- state  output  2  0=LOAD, 1=RUN, 2=PAUSE (3 unused)
- collision_count  output  8  collision rising edges since last load, saturating

Behaviour:
- All outputs registered. One clock; "one cycle" means one clock_162 period.
- Reset (rst=1 at an edge):
  - state=LOAD, load=1, step_en=0, sel_latched=0, collision_count=0.
  - Debounce candidate=0 and counter=0; load counter=0; divider=0; button/collision edge registers=0.
  - Reset mid-operation aborts everything, including a LOAD in progress.
- Debounce:
  - If sel_raw != cand: cand<=sel_raw, dcnt<=0.
  - Else if dcnt<DEBOUNCE-1: dcnt++.
  - stable = (sel_raw==cand) && (dcnt==DEBOUNCE-1).
  - If stable && cand!=sel_latched: sel_latched<=cand and enter LOAD (lcnt<=0).
  - Acceptance occurs on the DEBOUNCE-th edge after the first edge sampling the new value.
  - Glitches shorter than that are ignored. Returning to the latched value causes no reload.
- Edge detect: pause_btn, step_btn and collision are each registered once; an edge event is cur&&!prev.
- LOAD:
  - load=1, step_en=0.
  - lcnt increments each cycle; when lcnt==LOAD_CYCLES-1, next state is RUN with divider<=0.
  - load is high for exactly LOAD_CYCLES cycles.
  - collision_count is held at 0.
  - Button edges are ignored.
  - A new accepted selection during LOAD restarts lcnt at 0.
- RUN:
  - Divider counts 0..STEP_DIV-1 and wraps.
  - step_en=1 for the single cycle after divider==STEP_DIV-1, so the first pulse is STEP_DIV cycles after entering RUN, then every STEP_DIV cycles.
  - A pause edge moves to PAUSE and clears the divider; no step pulse is issued in that cycle.
- PAUSE:
  - Divider frozen at 0.
  - A step_btn edge gives step_en=1 for exactly one cycle; holding the button gives one pulse only.
  - A pause edge returns to RUN; the divider starts at 0.
  - A simultaneous pause and step edge: the pause edge wins and no pulse is issued.
- Priority: rst > accepted selection (any state -> LOAD) > pause edge > step edge / divider.
- Collision counter:
  - In RUN or PAUSE, each collision rising edge increments collision_count, saturating at 255.
  - It is cleared on entry to LOAD.
- STEP_DIV=1: step_en is continuously high in RUN.
- LOAD_CYCLES=1: load is a single-cycle pulse.

Test Plan:
(Use DEBOUNCE=4, LOAD_CYCLES=3, STEP_DIV=5.)
- Reset release, sel_raw=0 held -> load=1 for 3 cycles, state goes 0->1, first step_en 5 cycles after RUN entry, then every 5 cycles; sel_latched=0.
- sel_raw 0->3 held -> sel_latched=3 on the 4th edge after first sample, load high 3 cycles, step_en=0 throughout LOAD. A 3-cycle glitch to 7 then back to 3 -> no change, no reload.
- In RUN, pulse pause_btn -> state=2, no step_en. Hold step_btn 10 cycles -> exactly one step_en. Pause and step edges in the same cycle -> state=1, no pulse.
- 300 collision rising edges in RUN -> collision_count saturates at 255. A level held high counts once. A new selection accepted -> count=0.
- New selection accepted during LOAD (lcnt=1) -> lcnt restarts and load stays high 3 further cycles. Assert rst mid-RUN -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/sim_sequencer.sv
// Run controller between the board switches/buttons and physics_engine: debounces and latches
// the scenario select, sequences LOAD -> RUN <-> PAUSE and produces rate-divided step pulses.
module sim_sequencer #(
    parameter int DEBOUNCE    = 1_620_000,
    parameter int LOAD_CYCLES = 16,
    parameter int STEP_DIV    = 2_700_000
) (
    input  logic        clock_162,
    input  logic        rst,
    input  logic [15:0] sel_raw,
    input  logic        pause_btn,
    input  logic        step_btn,
    input  logic        collision,
    output logic [15:0] sel_latched,
    output logic        load,
    output logic        step_en,
    output logic [1:0]  state,
    output logic [7:0]  collision_count
);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int VW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);
    localparam logic [LW-1:0] LMAX = LW'(LOAD_CYCLES - 1);
    localparam logic [VW-1:0] VMAX = VW'(STEP_DIV - 1);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic          load_reg, load_next;
    logic          step_en_reg, step_en_next;
    logic [15:0]   sel_latched_reg, sel_latched_next;
    logic [7:0]    coll_cnt_reg, coll_cnt_next;
    logic [15:0]   cand_reg, cand_next;
    logic [DW-1:0] dcnt_reg, dcnt_next;
    logic [LW-1:0] lcnt_reg, lcnt_next;
    logic [VW-1:0] div_reg, div_next;

    // Bit 0 = pause, bit 1 = step, bit 2 = collision
    logic [2:0] btn_cur, btn_prev_reg, btn_edge;
    logic       pause_edge, step_edge, coll_edge;
    logic       sel_accept;

    assign btn_cur = {collision, step_btn, pause_btn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            assign btn_edge[gi] = btn_cur[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    assign pause_edge = btn_edge[0];
    assign step_edge  = btn_edge[1];
    assign coll_edge  = btn_edge[2];

    // A value must be seen unchanged for DEBOUNCE consecutive edges, and differ from the
    // current scenario, before it triggers a reload.
    assign sel_accept = (sel_raw == cand_reg) && (dcnt_reg == DMAX) &&
                        (cand_reg != sel_latched_reg);

    always_comb begin
        state_next       = state_reg;
        load_next        = load_reg;
        step_en_next     = 1'b0;
        sel_latched_next = sel_latched_reg;
        coll_cnt_next    = coll_cnt_reg;
        cand_next        = cand_reg;
        dcnt_next        = dcnt_reg;
        lcnt_next        = lcnt_reg;
        div_next         = div_reg;

        if (sel_raw != cand_reg) begin
            cand_next = sel_raw;
            dcnt_next = '0;
        end else if (dcnt_reg != DMAX) begin
            dcnt_next = dcnt_reg + DW'(1);
        end

        if (sel_accept) begin
            sel_latched_next = cand_reg;
            state_next       = ST_LOAD;
            load_next        = 1'b1;
            lcnt_next        = '0;
            div_next         = '0;
            coll_cnt_next    = '0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    coll_cnt_next = '0;
                    load_next     = 1'b1;
                    if (lcnt_reg == LMAX) begin
                        state_next = ST_RUN;
                        load_next  = 1'b0;
                        div_next   = '0;
                    end else begin
                        lcnt_next = lcnt_reg + LW'(1);
                    end
                end
                ST_RUN: begin
                    if (pause_edge) begin
                        state_next = ST_PAUSE;
                        div_next   = '0;
                    end else if (div_reg == VMAX) begin
                        div_next     = '0;
                        step_en_next = 1'b1;
                    end else begin
                        div_next = div_reg + VW'(1);
                    end
                end
                ST_PAUSE: begin
                    div_next = '0;
                    if (pause_edge) begin
                        state_next = ST_RUN;
                    end else if (step_edge) begin
                        step_en_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_LOAD;
                    load_next  = 1'b1;
                    lcnt_next  = '0;
                end
            endcase

            if ((state_reg == ST_RUN || state_reg == ST_PAUSE) && coll_edge &&
                coll_cnt_reg != 8'hFF) begin
                coll_cnt_next = coll_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clock_162) begin
        if (rst) begin
            state_reg       <= ST_LOAD;
            load_reg        <= 1'b1;
            step_en_reg     <= 1'b0;
            sel_latched_reg <= '0;
            coll_cnt_reg    <= '0;
            cand_reg        <= '0;
            dcnt_reg        <= '0;
            lcnt_reg        <= '0;
            div_reg         <= '0;
            btn_prev_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            load_reg        <= load_next;
            step_en_reg     <= step_en_next;
            sel_latched_reg <= sel_latched_next;
            coll_cnt_reg    <= coll_cnt_next;
            cand_reg        <= cand_next;
            dcnt_reg        <= dcnt_next;
            lcnt_reg        <= lcnt_next;
            div_reg         <= div_next;
            btn_prev_reg    <= btn_cur;
        end
    end

    assign state           = state_reg;
    assign load            = load_reg;
    assign step_en         = step_en_reg;
    assign sel_latched     = sel_latched_reg;
    assign collision_count = coll_cnt_reg;

endmodule

// File: tb/tb_sim_sequencer.sv
// Directed bench for sim_sequencer: a vector table for reset/run/pause behaviour, then short
// hand-written sequences for debounce, saturation, reload restart and mid-run reset.
module tb_sim_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sel_raw, sel_raw_b;
    logic        pause_btn, step_btn, collision;
    logic [15:0] sel_latched, sel_latched_b;
    logic        load, load_b, step_en, step_en_b;
    logic [1:0]  state, state_b;
    logic [7:0]  collision_count, collision_count_b;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sim_sequencer #(.DEBOUNCE(4), .LOAD_CYCLES(3), .STEP_DIV(5)) u_dut (
        .clock_162(clk), .rst(rst), .sel_raw(sel_raw), .pause_btn(pause_btn),
        .step_btn(step_btn), .collision(collision), .sel_latched(sel_latched),
        .load(load), .step_en(step_en), .state(state), .collision_count(collision_count)
    );

    // Single-cycle debounce lets a second selection be accepted while lcnt is still 1.
    sim_sequencer #(.DEBOUNCE(1), .LOAD_CYCLES(3), .STEP_DIV(5)) u_dut_b (
        .clock_162(clk), .rst(rst), .sel_raw(sel_raw_b), .pause_btn(pause_btn),
        .step_btn(step_btn), .collision(collision), .sel_latched(sel_latched_b),
        .load(load_b), .step_en(step_en_b), .state(state_b), .collision_count(collision_count_b)
    );

    typedef struct {
        logic        rst;
        logic [15:0] sel;
        logic        p, s, c;
        logic [15:0] e_sel;
        logic        e_load, e_step;
        logic [1:0]  e_state;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [15:0] sl, input logic p, input logic s,
                       input logic c, input logic [15:0] es, input logic el, input logic est,
                       input logic [1:0] ek, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.sel = sl; v.p = p; v.s = s; v.c = c;
        v.e_sel = es; v.e_load = el; v.e_step = est; v.e_state = ek; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            $display("[TB] ok %s = %0d", name, got);
        end
    endtask

    task automatic check_row(input string name, input logic [15:0] es, input logic el,
                             input logic est, input logic [1:0] ek, input logic [7:0] ec);
        tests++;
        if (sel_latched !== es || load !== el || step_en !== est || state !== ek ||
            collision_count !== ec) begin
            failed++;
            $display("FAIL %s: got sel=%0d load=%0b step=%0b state=%0d cnt=%0d, want sel=%0d load=%0b step=%0b state=%0d cnt=%0d",
                     name, sel_latched, load, step_en, state, collision_count, es, el, est, ek, ec);
        end else begin
            $display("[TB] ok %s sel=%0d load=%0b step=%0b state=%0d cnt=%0d",
                     name, sel_latched, load, step_en, state, collision_count);
        end
    endtask

    initial begin
        rst = 1'b1; sel_raw = '0; sel_raw_b = '0;
        pause_btn = 1'b0; step_btn = 1'b0; collision = 1'b0;

        //  rst sel p s c | sel load step state cnt
        add(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);   // RUN entry, divider 0
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0);   // first pulse, 5 cycles after entry
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
        add(0, 0, 0, 0, 1,  0, 0, 0, 1, 1);   // collision edge
        add(0, 0, 0, 0, 1,  0, 0, 0, 1, 1);   // held level: no count
        add(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1,  0, 0, 0, 1, 2);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 2);
        add(0, 0, 1, 0, 0,  0, 0, 0, 2, 2);   // pause edge
        add(0, 0, 1, 0, 0,  0, 0, 0, 2, 2);
        add(0, 0, 0, 1, 0,  0, 0, 1, 2, 2);   // step edge -> one pulse
        add(0, 0, 0, 1, 0,  0, 0, 0, 2, 2);
        add(0, 0, 0, 1, 0,  0, 0, 0, 2, 2);
        add(0, 0, 0, 1, 1,  0, 0, 0, 2, 3);   // collision counts while paused
        for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 0, 0, 0, 0, 2, 3);
        add(0, 0, 0, 0, 0,  0, 0, 0, 2, 3);
        add(0, 0, 1, 1, 0,  0, 0, 0, 1, 3);   // pause+step together: resume, no pulse
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 3);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; sel_raw = vecs[i].sel;
            pause_btn = vecs[i].p; step_btn = vecs[i].s; collision = vecs[i].c;
            tick();
            check_row($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_load, vecs[i].e_step,
                      vecs[i].e_state, vecs[i].e_cnt);
        end

        // Selection 0 -> 3: accepted on the 4th edge after first sample.
        sel_raw = 16'd3;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_row($sformatf("deb_wait%0d", k), 0, 0, 0, 1, 3);
        end
        tick(); check_row("deb_accept", 3, 1, 0, 0, 0);
        tick(); check_row("load_1", 3, 1, 0, 0, 0);
        tick(); check_row("load_2", 3, 1, 0, 0, 0);
        tick(); check_row("load_end", 3, 0, 0, 1, 0);

        // Three-cycle glitch to 7 is ignored and the return to 3 causes no reload.
        sel_raw = 16'd7;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) sel_raw = 16'd3;
            tick();
            check_row($sformatf("glitch%0d", k), 3, 0, (k == 4 || k == 9), 1, 0);
        end

        for (int n = 1; n <= 300; n++) begin
            collision = 1'b1;
            tick();
            check_val($sformatf("coll_sat%0d", n), collision_count, (n > 255) ? 255 : n);
            collision = 1'b0;
            tick();
        end

        // New selection clears the saturated counter.
        sel_raw = 16'd5;
        for (int k = 0; k < 4; k++) tick();
        check_val("sel5_pre_sel", sel_latched, 3);
        check_val("sel5_pre_cnt", collision_count, 255);
        tick();
        check_row("sel5_accept", 5, 1, 0, 0, 0);
        tick(); check_val("sel5_load1", load, 1);
        tick(); check_val("sel5_load2", load, 1);
        tick(); check_val("sel5_run", state, 1);
        check_val("sel5_load_off", load, 0);
        collision = 1'b1;
        tick(); check_val("cnt_after_sel5", collision_count, 1);
        collision = 1'b0;

        // Second selection accepted while lcnt == 1 restarts the load window.
        sel_raw_b = 16'd1;
        tick();
        tick();
        check_val("b_accept1_sel", sel_latched_b, 1);
        check_val("b_accept1_load", load_b, 1);
        sel_raw_b = 16'd2;
        tick(); check_val("b_lcnt1_load", load_b, 1);
        tick();
        check_val("b_accept2_sel", sel_latched_b, 2);
        check_val("b_accept2_load", load_b, 1);
        tick(); check_val("b_restart_load1", load_b, 1);
        tick(); check_val("b_restart_load2", load_b, 1);
        check_val("b_restart_state2", state_b, 0);
        tick(); check_val("b_restart_done_load", load_b, 0);
        check_val("b_restart_done_state", state_b, 1);

        // Reset mid-run returns every output to its reset value at the next edge.
        check_val("pre_rst_state", state, 1);
        rst = 1'b1;
        tick();
        check_row("mid_rst", 0, 1, 0, 0, 0);
        check_val("mid_rst_b_sel", sel_latched_b, 0);
        rst = 1'b0;
        tick(); check_row("post_rst1", 0, 1, 0, 0, 0);
        tick(); check_row("post_rst2", 0, 1, 0, 0, 0);
        tick(); check_row("post_rst3", 0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
